// File: rtl/vespa_priority_capture_n_if.sv
// vespa_priority_capture_n_if: request/grant bundle for the N-channel priority capture.
interface vespa_priority_capture_n_if #(
   parameter int N_CH  = 4,
   parameter int PRI_W = 2
);
   localparam int IW = N_CH > 1 ? $clog2(N_CH) : 1;
   logic                  arm;
   logic [N_CH-1:0]       req;
   logic [N_CH*PRI_W-1:0] pri;
   logic                  rel;
   logic                  lost_clr;
   logic [N_CH-1:0]       grant;
   logic                  grant_vld;
   logic [IW-1:0]         grant_id;
   logic [N_CH-1:0]       lost;
   logic                  busy;
   modport master (output arm, req, pri, rel, lost_clr,
                   input  grant, grant_vld, grant_id, lost, busy);
   modport slave  (input  arm, req, pri, rel, lost_clr,
                   output grant, grant_vld, grant_id, lost, busy);
endinterface

// File: rtl/vespa_priority_capture_n.sv
// vespa_priority_capture_n: first-arrival N-channel capture with per-channel skew, one-hot grant held until release.
module vespa_priority_capture_n #(
   parameter int N_CH     = 4,
   parameter int PRI_W    = 2,
   parameter int HOLD_CYC = 0
) (
   input logic clk,
   input logic rst,
   vespa_priority_capture_n_if.slave bus
);
   localparam int IW = N_CH > 1 ? $clog2(N_CH) : 1;
   localparam int HW = HOLD_CYC > 0 ? $clog2(HOLD_CYC + 1) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC == 0 ? 0 : HOLD_CYC - 1);
   typedef enum logic [1:0] {IDLE, ARMED, LOCKED} state_t;
   state_t state, state_n;
   logic [N_CH-1:0] req_q, rise, act, act_n, cand, win, win_n, lost_r, lost_n, lost_set, sel;
   logic [PRI_W-1:0] cnt [N_CH];
   logic [PRI_W-1:0] cnt_n [N_CH];
   logic [PRI_W-1:0] pv;
   logic [IW-1:0] id_r, id_n, sel_id;
   logic [HW-1:0] hcnt, hcnt_n;
   logic busy_r, busy_n, timeout;
   // A pri=0 arrival is a candidate in its own cycle; otherwise the load cycle counts as the first skew clock.
   always_comb begin
      rise = bus.req & ~req_q;
      cand = '0;
      act_n = act;
      cnt_n = cnt;
      sel_id = '0;
      for (int c = N_CH - 1; c >= 0; c--) begin
         pv = bus.pri[c*PRI_W +: PRI_W];
         cand[c] = act[c] ? (cnt[c] == '0) : (rise[c] && pv == '0);
         if (cand[c]) sel_id = IW'(c);
         if (act[c]) cnt_n[c] = cnt[c] - 1'b1;
         else if (rise[c]) begin
            act_n[c] = 1'b1;
            cnt_n[c] = pv - 1'b1;
         end
      end
      pv = '0;
      sel = N_CH'(1) << sel_id;
      timeout = HOLD_CYC != 0 && hcnt == HOLD_LAST;
      state_n = state;
      win_n = win;
      id_n = id_r;
      lost_set = '0;
      hcnt_n = hcnt;
      case (state)
         IDLE: begin
            act_n = '0;
            state_n = bus.arm ? ARMED : IDLE;
         end
         ARMED: begin
            if (|cand) begin
               state_n = LOCKED;
               act_n = '0;
               win_n = sel;
               id_n = sel_id;
               lost_set = (act | rise) & ~sel;
               hcnt_n = '0;
            end else if (!bus.arm) begin
               state_n = IDLE;
               act_n = '0;
            end
         end
         LOCKED: begin
            act_n = '0;
            lost_set = rise;
            hcnt_n = HOLD_CYC != 0 ? hcnt + 1'b1 : hcnt;
            if (bus.rel || timeout) begin
               state_n = bus.arm ? ARMED : IDLE;
               hcnt_n = '0;
            end
         end
         default: begin
            state_n = IDLE;
            act_n = '0;
         end
      endcase
      lost_n = (lost_r & ~{N_CH{bus.lost_clr}}) | lost_set;
      busy_n = state_n == LOCKED || (state_n == ARMED && |act_n);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         req_q <= '0;
         act <= '0;
         cnt <= '{default: '0};
         win <= '0;
         id_r <= '0;
         lost_r <= '0;
         hcnt <= '0;
         busy_r <= 1'b0;
      end else begin
         state <= state_n;
         req_q <= bus.req;
         act <= act_n;
         cnt <= cnt_n;
         win <= win_n;
         id_r <= id_n;
         lost_r <= lost_n;
         hcnt <= hcnt_n;
         busy_r <= busy_n;
      end
   end
   assign bus.grant = state == LOCKED ? win : '0;
   assign bus.grant_vld = state == LOCKED;
   assign bus.grant_id = state == LOCKED ? id_r : '0;
   assign bus.lost = lost_r;
   assign bus.busy = busy_r;
endmodule
